// File: rtl/ring_output_scheduler.sv
// rtl/ring_output_scheduler.sv - two-requester, two-VC output scheduler for one ring link
// Optional macro RING_OSCHED_ROTATE_ALWAYS_EN: rotate priority on every grant, not only on contention.
module ring_output_scheduler #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              req0_valid,
    input  logic              req0_vc,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_grant,
    input  logic              req1_valid,
    input  logic              req1_vc,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_grant,
    output logic              out_valid,
    output logic              out_vc,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              polarity_q;
    logic [1:0]        slot_full_q, slot_full_d;
    logic [DATA_W-1:0] slot_data_q [2];
    logic [DATA_W-1:0] slot_data_d [2];
    logic [1:0]        last_gnt_q, last_gnt_d;

    logic phase, drain_vc;
    logic elig0, elig1, gnt0, gnt1;

    assign phase    = polarity_q;
    assign drain_vc = ~polarity_q;

    // Grants are gated by reset so they fall the moment reset asserts, even with requests held.
    assign elig0 = reset && req0_valid && (req0_vc == phase) && !slot_full_q[phase];
    assign elig1 = reset && req1_valid && (req1_vc == phase) && !slot_full_q[phase];
    assign gnt0  = elig0 && (!elig1 || last_gnt_q[phase]);
    assign gnt1  = elig1 && (!elig0 || !last_gnt_q[phase]);

    assign polarity   = polarity_q;
    assign req0_grant = gnt0;
    assign req1_grant = gnt1;
    assign out_vc     = drain_vc;
    assign out_valid  = slot_full_q[drain_vc];
    assign out_data   = slot_data_q[drain_vc];

    always_comb begin
        slot_full_d    = slot_full_q;
        slot_data_d[0] = slot_data_q[0];
        slot_data_d[1] = slot_data_q[1];
        last_gnt_d     = last_gnt_q;
        // Fill targets the phase slot, drain the opposite one, so the two never collide.
        if (out_valid && out_ready) begin
            slot_full_d[drain_vc] = 1'b0;
        end
        if (gnt0 || gnt1) begin
            slot_full_d[phase] = 1'b1;
            slot_data_d[phase] = gnt1 ? req1_data : req0_data;
        end
`ifdef RING_OSCHED_ROTATE_ALWAYS_EN
        if (gnt0 || gnt1) begin
            last_gnt_d[phase] = gnt1;
        end
`else
        if (elig0 && elig1) begin
            last_gnt_d[phase] = gnt1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q     <= 1'b0;
            slot_full_q    <= 2'b00;
            slot_data_q[0] <= '0;
            slot_data_q[1] <= '0;
            last_gnt_q     <= 2'b11;
        end else begin
            polarity_q     <= ~polarity_q;
            slot_full_q    <= slot_full_d;
            slot_data_q[0] <= slot_data_d[0];
            slot_data_q[1] <= slot_data_d[1];
            last_gnt_q     <= last_gnt_d;
        end
    end

endmodule

// File: tb/tb_ring_output_scheduler.sv
// tb/tb_ring_output_scheduler.sv - directed self-checking bench for ring_output_scheduler
module tb_ring_output_scheduler;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              polarity;
    logic              req0_valid, req0_vc, req0_grant;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid, req1_vc, req1_grant;
    logic [DATA_W-1:0] req1_data;
    logic              out_valid, out_vc, out_ready;
    logic [DATA_W-1:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ring_output_scheduler #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .req0_valid (req0_valid),
        .req0_vc    (req0_vc),
        .req0_data  (req0_data),
        .req0_grant (req0_grant),
        .req1_valid (req1_valid),
        .req1_vc    (req1_vc),
        .req1_data  (req1_data),
        .req1_grant (req1_grant),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_vc = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_vc = 1'b0; req1_data = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_vc"},    {63'd0, out_vc},    64'd1);
        chk({tag, "_out_data"},  out_data,           64'd0);
        chk({tag, "_grant0"},    {63'd0, req0_grant}, 64'd0);
        chk({tag, "_grant1"},    {63'd0, req1_grant}, 64'd0);
    endtask

    // Reset mid-cycle, check outputs immediately, release on the negedge so polarity is 0.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        chk_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b0;
        idle();
        #1;
        chk_reset_outputs("por");
        chk("por_polarity", {63'd0, polarity}, 64'd0);

        // Polarity sequence after release
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("pol_0", {63'd0, polarity}, 64'd0);
        tick(); chk("pol_1", {63'd0, polarity}, 64'd1);
        tick(); chk("pol_2", {63'd0, polarity}, 64'd0);
        tick(); chk("pol_3", {63'd0, polarity}, 64'd1);
        tick();

        // Single packet at polarity 0
        req0_valid = 1'b1; req0_vc = 1'b0; req0_data = 64'hA5; out_ready = 1'b1;
        #1;
        chk("single_grant0", {63'd0, req0_grant}, 64'd1);
        chk("single_grant1", {63'd0, req1_grant}, 64'd0);
        tick(); req0_valid = 1'b0;
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_vc",    {63'd0, out_vc},    64'd0);
        chk("single_data",  out_data,           64'hA5);
        tick();
        chk("single_vc1_empty", {63'd0, out_valid}, 64'd0);
        tick();
        chk("single_drained_vc", {63'd0, out_vc},    64'd0);
        chk("single_drained",    {63'd0, out_valid}, 64'd0);

        // Contention on vc 0, with requests held through a reset
        req0_valid = 1'b1; req0_vc = 1'b0; req0_data = 64'h100;
        req1_valid = 1'b1; req1_vc = 1'b0; req1_data = 64'h200;
        reset_pulse("rst_mid_req");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_g0_%0d", i), {63'd0, req0_grant}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("cont_g1_%0d", i), {63'd0, req1_grant}, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            chk($sformatf("cont_odd_g_%0d", i), {62'd0, req0_grant, req1_grant}, 64'd0);
            chk($sformatf("cont_data_%0d", i), out_data, (i % 2 == 0) ? 64'h100 : 64'h200);
            tick();
        end
        tick();
        chk("mid_full_valid", {63'd0, out_valid}, 64'd1);
        reset_pulse("rst_mid_full");

        // Backpressure on slot 0 while slot 1 keeps flowing
        idle();
        reset_pulse("rst_bp");
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_vc = 1'b0; req0_data = 64'h11;
        #1;
        chk("bp_g0", {63'd0, req0_grant}, 64'd1);
        tick();
        req0_vc = 1'b1; req0_data = 64'h33;
        req1_valid = 1'b1; req1_vc = 1'b0; req1_data = 64'h22;
        #1;
        chk("bp_slot0_data", out_data, 64'h11);
        chk("bp_vc1_g0", {63'd0, req0_grant}, 64'd1);
        chk("bp_vc1_g1", {63'd0, req1_grant}, 64'd0);
        tick();
        req0_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_full_g1", {63'd0, req1_grant}, 64'd0);
        chk("bp_slot1_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_slot1_data", out_data, 64'h33);
        tick();
        chk("bp_represent_vc",   {63'd0, out_vc},    64'd0);
        chk("bp_represent_data", out_data,           64'h11);
        chk("bp_hold_g1",        {63'd0, req1_grant}, 64'd0);
        tick();
        chk("bp_release_g1", {63'd0, req1_grant}, 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("bp_out_data", out_data, 64'h22);

        // Priority rotation after an uncontended win
        idle();
        reset_pulse("rst_macro");
        req0_valid = 1'b1; req0_vc = 1'b0; req0_data = 64'h44;
        #1;
        chk("macro_solo_g0", {63'd0, req0_grant}, 64'd1);
        tick();
        req1_valid = 1'b1; req1_vc = 1'b0; req1_data = 64'h45;
        chk("macro_solo_data", out_data, 64'h44);
        tick();
`ifdef RING_OSCHED_ROTATE_ALWAYS_EN
        chk("macro_cont_g0", {63'd0, req0_grant}, 64'd0);
        chk("macro_cont_g1", {63'd0, req1_grant}, 64'd1);
`else
        chk("macro_cont_g0", {63'd0, req0_grant}, 64'd1);
        chk("macro_cont_g1", {63'd0, req1_grant}, 64'd0);
`endif

        // Mixed VCs
        idle();
        reset_pulse("rst_mixed");
        req0_valid = 1'b1; req0_vc = 1'b1; req0_data = 64'h55;
        req1_valid = 1'b1; req1_vc = 1'b0; req1_data = 64'h66;
        #1;
        chk("mix_p0_g", {62'd0, req0_grant, req1_grant}, 64'd1);
        tick();
        chk("mix_p1_g", {62'd0, req0_grant, req1_grant}, 64'd2);
        chk("mix_p1_out", {out_valid, out_vc, out_data[7:0]}, {54'd0, 2'b10, 8'h66});
        tick();
        chk("mix_p0b_g", {62'd0, req0_grant, req1_grant}, 64'd1);
        chk("mix_p0b_out", {out_valid, out_vc, out_data[7:0]}, {54'd0, 2'b11, 8'h55});
        tick();
        chk("mix_p1b_out", {out_valid, out_vc, out_data[7:0]}, {54'd0, 2'b10, 8'h66});

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_output_scheduler.md
# ring_output_scheduler

Two-requester, two-virtual-channel output scheduler for one ring-router output link in the multi-core processor system. Arbitrates the two input buffers competing for the link with a per-channel rotating priority. Captures each winner into a one-entry output slot per virtual channel. Drains the slots onto the link on alternating cycles under a free-running even/odd polarity. One instance sits in front of each router output port, between the input buffers and the outgoing link.

## Interface
- DATA_W, 64, packet width in bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs
- polarity  out  1  current phase; toggles every cycle; VC arbitrated this cycle
- req0_valid  in  1  requester 0 has a packet
- req0_vc  in  1  virtual channel of requester 0's packet
- req0_data  in  DATA_W  requester 0 packet
- req0_grant  out  1  requester 0's packet is captured at the coming edge
- req1_valid, req1_vc, req1_data, req1_grant  same as requester 0
- out_valid  out  1  output slot for out_vc holds a packet
- out_vc  out  1  channel presented on the link, always ~polarity
- out_data  out  DATA_W  packet on the link
- out_ready  in  1  downstream accepts out_data this cycle

## Operation
- State:
  - polarity register
  - slot_full[1:0] and slot_data[1:0], indexed by VC
  - last_gnt[1:0], one bit per VC; 1 means requester 1 won that VC last
- Arbitration, phase p = polarity:
  - Requester i is eligible iff reqi_valid, reqi_vc==p and !slot_full[p].
  - Only one eligible: it is granted.
  - Both eligible: requester 0 wins if last_gnt[p]==1, else requester 1.
  - Grants are combinational from inputs and state; at most one per cycle; never to a VC other than p.
- Capture:
  - On grant, slot_data[p] <= winner data and slot_full[p] <= 1 at the edge.
  - The requester must treat the grant as a pop.
- last_gnt[p] update (macro-dependent, see Configuration):
  - Default: updates only in a cycle where both requesters are eligible; set to the winner's index.
  - Otherwise unchanged.
- Drain:
  - s = ~polarity, out_vc = s, out_valid = slot_full[s], out_data = slot_data[s].
  - out_valid && out_ready clears slot_full[s] at the edge.
  - out_valid && !out_ready holds the slot; the packet is re-presented two cycles later.
- Fill and drain never touch the same slot in one cycle; no bypass path exists.
- Full slot: requesters for that VC get no grant until it drains; the other VC is unaffected.
- VC-mismatched requests (reqi_vc != polarity) wait for the matching phase.

## Timing
- Reset, asynchronous and immediate:
  - polarity=0, slot_full=0, slot_data=0, last_gnt=2'b11.
  - Outputs: out_valid=0, out_vc=1, out_data=0, both grants 0.
- First edge after release: polarity=1. Polarity alternates on every edge thereafter.
- Latency: grant in cycle t (phase p) leads to out_valid with out_vc=p in cycle t+1.
- Peak throughput: one packet per cycle, alternating VCs.
- Reset asserted mid-operation: buffered packets are dropped and grants fall the same cycle. Requesters keep their packets.
- No X on outputs after reset, for any input combination.

## Configuration
- RING_OSCHED_ROTATE_ALWAYS_EN
  - Defined: last_gnt[p] updates on every grant, including uncontended ones.
  - Undefined: updates only on contention, as in Operation.

## Test plan
- Reset: drive reset=0 mid-run -> outputs immediately out_valid=0, out_vc=1, out_data=0, grants 0. After release, polarity sequence is 0,1,0,1.
- Single packet: at polarity 0, req0_valid=1, req0_vc=0, req0_data=0xA5, out_ready=1 -> req0_grant=1 that cycle. Next cycle out_valid=1, out_vc=0, out_data=0xA5, then the slot empties.
- Contention: both requesters hold vc 0 continuously, out_ready=1 -> grants on polarity-0 cycles go req0, req1, req0, req1. No grants on polarity-1 cycles.
- Backpressure: out_ready=0 with slot 0 full, req1 holding vc 0 -> no req1_grant; slot 1 traffic still flows. Raising out_ready drains slot 0 -> req1_grant on the next polarity-0 cycle.
- Macro: req0 alone wins vc 0, then both contend on vc 0 -> without the macro req0 wins; with RING_OSCHED_ROTATE_ALWAYS_EN req1 wins.
- Mixed VCs: req0 vc 1 and req1 vc 0 held -> req1 granted on polarity 0, req0 on polarity 1. Link output alternates out_vc 0/1 each cycle.
